// File: rtl/pipe_buffer_elastic.sv
// rtl/pipe_buffer_elastic.sv - elastic valid/ready pipeline stage buffer with flush and NOP fill
module pipe_buffer_elastic #(
    parameter int                 WIDTH     = 64,
    parameter int                 DEPTH     = 1,
    parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
    localparam int                OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH:0]   stage_ready;
    logic [OCC_W-1:0] occ_count;

    // Readiness ripples back from the output: a stage can take data if it is
    // empty (bubble collapse) or if the stage after it is moving this cycle.
    always_comb begin
        stage_ready        = '0;
        stage_ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            stage_ready[i] = ~stage_valid[i] | stage_ready[i + 1];
        end
    end

    // Count of occupied stages, tracks the valid bits directly.
    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + OCC_W'(stage_valid[i]);
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : NOP_VALUE;
    assign occupancy = occ_count;

    // Stage registers: flush empties every stage (dropping any same-cycle input);
    // otherwise each ready stage loads from its predecessor and stalled stages hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= NOP_VALUE;
            end
        end else if (flush) begin
            stage_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= NOP_VALUE;
            end
        end else begin
            if (stage_ready[0]) begin
                stage_valid[0] <= in_valid;
                stage_data[0]  <= in_valid ? in_data : NOP_VALUE;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_data[i]  <= stage_valid[i-1] ? stage_data[i-1] : NOP_VALUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_buffer_elastic.sv
// tb/tb_pipe_buffer_elastic.sv - directed self-checking bench for pipe_buffer_elastic
module tb_pipe_buffer_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // dut_a: DEPTH=3, NOP=0
    logic        a_rst_n, a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    // dut_b: DEPTH=4, NOP=0
    logic        b_rst_n, b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;
    // dut_c: DEPTH=2, NOP=0x20
    logic        c_rst_n, c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [1:0]  c_occ;

    pipe_buffer_elastic #(.WIDTH(32), .DEPTH(3), .NOP_VALUE(32'h0)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .occupancy(a_occ));

    pipe_buffer_elastic #(.WIDTH(32), .DEPTH(4), .NOP_VALUE(32'h0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .occupancy(b_occ));

    pipe_buffer_elastic #(.WIDTH(32), .DEPTH(2), .NOP_VALUE(32'h0000_0020)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .occupancy(c_occ));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 0; a_in_valid = 0; a_in_data = 0; a_flush = 0; a_out_ready = 0;
        b_rst_n = 0; b_in_valid = 0; b_in_data = 0; b_flush = 0; b_out_ready = 0;
        c_rst_n = 0; c_in_valid = 0; c_in_data = 0; c_flush = 0; c_out_ready = 0;
        #1;
        check_eq("a_reset_valid", 64'(a_out_valid), 64'd0);
        check_eq("a_reset_data",  64'(a_out_data),  64'd0);
        check_eq("a_reset_occ",   64'(a_occ),       64'd0);
        check_eq("a_reset_ready", 64'(a_in_ready),  64'd1);
        check_eq("c_reset_data",  64'(c_out_data),  64'h20);
        step(); step();
        a_rst_n = 1; b_rst_n = 1; c_rst_n = 1;
        step();

        // streaming, DEPTH=3, out_ready=1
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = 32'h11; step();
        check_eq("str_k_valid", 64'(a_out_valid), 64'd0);
        a_in_data = 32'h22; step();
        check_eq("str_k1_valid", 64'(a_out_valid), 64'd0);
        a_in_data = 32'h33; step();
        check_eq("str_k2_valid", 64'(a_out_valid), 64'd1);
        check_eq("str_k2_data",  64'(a_out_data),  64'h11);
        a_in_valid = 0; a_in_data = 0; step();
        check_eq("str_k3_valid", 64'(a_out_valid), 64'd1);
        check_eq("str_k3_data",  64'(a_out_data),  64'h22);
        step();
        check_eq("str_k4_valid", 64'(a_out_valid), 64'd1);
        check_eq("str_k4_data",  64'(a_out_data),  64'h33);
        step();
        check_eq("str_drain_valid", 64'(a_out_valid), 64'd0);
        check_eq("str_drain_occ",   64'(a_occ),       64'd0);

        // stall and fill, DEPTH=3, out_ready=0
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA; step();
        a_in_data = 32'hB; step();
        a_in_data = 32'hC; step();
        a_in_data = 32'hD;
        check_eq("fill_occ",      64'(a_occ),       64'd3);
        check_eq("fill_in_ready", 64'(a_in_ready),  64'd0);
        check_eq("fill_head",     64'(a_out_data),  64'hA);
        step();
        check_eq("fill_frozen_head", 64'(a_out_data), 64'hA);
        check_eq("fill_frozen_occ",  64'(a_occ),      64'd3);
        a_out_ready = 1; #1;
        check_eq("pass_in_ready", 64'(a_in_ready), 64'd1);
        step();
        a_out_ready = 0; a_in_valid = 0; a_in_data = 0;
        check_eq("pass_occ",  64'(a_occ),      64'd3);
        check_eq("pass_head", 64'(a_out_data), 64'hB);
        a_out_ready = 1; step();
        check_eq("drain_c", 64'(a_out_data), 64'hC);
        step();
        check_eq("drain_d", 64'(a_out_data), 64'hD);
        step();
        check_eq("drain_empty", 64'(a_out_valid), 64'd0);

        // flush with a concurrent input handshake
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h1; step();
        a_in_data = 32'h2; step();
        a_in_data = 32'h3; step();
        check_eq("pre_flush_occ", 64'(a_occ), 64'd3);
        a_out_ready = 1; a_in_data = 32'hDEAD; a_flush = 1; step();
        a_flush = 0; a_in_valid = 0; a_in_data = 0;
        check_eq("flush_occ",   64'(a_occ),       64'd0);
        check_eq("flush_valid", 64'(a_out_valid), 64'd0);
        check_eq("flush_data",  64'(a_out_data),  64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("post_flush_valid", 64'(a_out_valid), 64'd0);
        end

        // asynchronous reset mid-stream with 2 items held
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h77; step();
        a_in_data = 32'h88; step();
        a_in_valid = 0; a_in_data = 0;
        check_eq("pre_rst_occ", 64'(a_occ), 64'd2);
        #2 a_rst_n = 0; #1;
        check_eq("rst_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst_data",  64'(a_out_data),  64'd0);
        check_eq("rst_occ",   64'(a_occ),       64'd0);
        check_eq("rst_ready", 64'(a_in_ready),  64'd1);
        step(); a_rst_n = 1; step();

        // bubble collapse, DEPTH=4, out_ready=0
        b_in_valid = 1; b_in_data = 32'hA; step();
        b_in_valid = 0; b_in_data = 0; step(); step();
        b_in_valid = 1; b_in_data = 32'hB; step();
        b_in_valid = 0; b_in_data = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("bub_occ",   64'(b_occ),       64'd2);
        check_eq("bub_ready", 64'(b_in_ready),  64'd1);
        check_eq("bub_head",  64'(b_out_data),  64'hA);
        b_out_ready = 1; step();
        check_eq("bub_next_valid", 64'(b_out_valid), 64'd1);
        check_eq("bub_next_data",  64'(b_out_data),  64'hB);
        check_eq("bub_next_occ",   64'(b_occ),       64'd1);

        // NOP masking, DEPTH=2, NOP=0x20
        c_out_ready = 1;
        check_eq("nop_idle", 64'(c_out_data), 64'h20);
        c_in_valid = 1; c_in_data = 32'h55; step();
        c_in_valid = 0; c_in_data = 0;
        check_eq("nop_k_valid", 64'(c_out_valid), 64'd0);
        check_eq("nop_k_data",  64'(c_out_data),  64'h20);
        step();
        check_eq("nop_item_valid", 64'(c_out_valid), 64'd1);
        check_eq("nop_item_data",  64'(c_out_data),  64'h55);
        step();
        check_eq("nop_after_valid", 64'(c_out_valid), 64'd0);
        check_eq("nop_after_data",  64'(c_out_data),  64'h20);
        step();
        check_eq("nop_later_data", 64'(c_out_data), 64'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_buffer_elastic.md
Name: pipe_buffer_elastic

Overview:
- Parametrised successor to the fixed-width stage buffers between IF/ID/EX/MEM/WB.
- Chains DEPTH register stages of WIDTH bits. Each stage carries a valid bit.
- Uses a valid/ready handshake, so the pipeline can stall from downstream, collapse bubbles, and be flushed on a taken branch.
- Empty slots present a configurable NOP word, so downstream decode sees a harmless instruction.

Parameters:
- WIDTH, 64, payload bits per stage. Legal range is 1 or more.
- DEPTH, 1, number of register stages. Legal range is 1 or more.
- NOP_VALUE, {WIDTH{1'b0}}, word driven on out_data and loaded into emptied stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream offers in_data this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  payload from the upstream stage.
- flush  input  1  synchronous kill of all held and incoming items.
- out_valid  output  1  stage DEPTH-1 holds a valid item.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  WIDTH  payload of stage DEPTH-1, or NOP_VALUE when empty.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits v[i] clear to 0.
  - All data registers d[i] load NOP_VALUE.
  - Resulting outputs: out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1.
  - Reset deassertion takes effect at the first clk edge after rst_n rises.
- Stage readiness (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = ~v[i] | r[i+1].
  - in_ready = r[0].
  - Bubble collapsing: an empty stage accepts data even when everything downstream is stalled.
- Transfer on each edge, for stage i when r[i]=1:
  - Stage 0: v[0] <= in_valid & in_ready; d[0] <= in_valid ? in_data : NOP_VALUE.
  - Stage i>0: v[i] <= v[i-1]; d[i] <= v[i-1] ? d[i-1] : NOP_VALUE.
- Hold: when r[i]=0, stage i keeps v[i] and d[i] unchanged. This is the stall case.
- Handshakes:
  - Input handshake occurs when in_valid & in_ready.
  - Output handshake occurs when out_valid & out_ready.
  - Once out_valid is asserted, out_data stays stable until the output handshake.
- Latency: an item accepted at edge k appears on out_valid at edge k+DEPTH-1, provided there are no stalls.
- Throughput: 1 item per cycle while out_ready=1.
- out_data = v[DEPTH-1] ? d[DEPTH-1] : NOP_VALUE. It never shows stale payload.
- occupancy = popcount(v). It updates on the same edge as v.
- Flush (flush=1 at an edge):
  - All v[i] <= 0 and all d[i] <= NOP_VALUE, regardless of out_ready.
  - An input handshake in the same cycle is discarded.
  - An output handshake in the same cycle still counts as delivered, because downstream already sampled it.
  - in_ready is not masked by flush; upstream treats its offered item as consumed.
- Simultaneous events: flush has priority over transfer and hold. Reset has priority over everything.
- Full pipeline with out_ready=0: in_ready=0, occupancy=DEPTH, all registers frozen.
- Full pipeline with out_ready=1: in_ready=1 (pass-through readiness), so streaming continues with no bubble.
- DEPTH=1 degenerates to a single register with valid and stall. in_ready = ~v[0] | out_ready.
- Combinational path: in_ready depends on out_ready through DEPTH OR gates. This is accepted by design; there is no skid register in this generation.

Test Plan:
- Reset: WIDTH=32, DEPTH=3, NOP_VALUE=0. Pulse rst_n low mid-stream with 2 items held.
  - Required: immediately out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Streaming: DEPTH=3, out_ready=1. Feed 0x11, 0x22, 0x33 on consecutive edges k, k+1, k+2.
  - Required: out_valid rises at edge k+2 with out_data=0x11, then 0x22 and 0x33 on following cycles. No gaps.
- Stall and fill: DEPTH=3, out_ready=0, feed A, B, C, D every cycle.
  - Required: A, B, C accepted and occupancy=3. D sees in_ready=0.
  - Then raise out_ready for 1 cycle: A delivered, D accepted that cycle, occupancy stays 3.
- Bubble collapse: DEPTH=4, out_ready=0. Inject A, idle 2 cycles, inject B.
  - Required: A reaches stage 3 and B compacts to stage 2; occupancy=2, in_ready=1.
- Flush: DEPTH=3 holding 3 items, in_valid=1 with in_data=0xDEAD, flush=1 for one edge.
  - Required next cycle: occupancy=0, out_valid=0, out_data=NOP_VALUE. 0xDEAD never appears at the output.
- NOP masking: NOP_VALUE=32'h0000_0020, DEPTH=2. Send one item then idle.
  - Required: out_data=0x20 whenever out_valid=0, including directly after the item drains.
